// File: rtl/nx1_dpram_sc.sv
// -----------------------------------------------------------------------------
// nx1_dpram_sc -- single-clock true-dual-port RAM for the X1 core.
//
// Port A is the CPU-side bus bridge and port B serves the video/DMA engines.
// Both ports share CLK. Each port has byte-enabled writes and registered read
// data, with a one-cycle acknowledge for every accepted access. A
// same-address collision has a fixed outcome and is flagged on COLL.
//
// Optional feature: define NX1_DPRAM_CLEAR_EN to build a post-reset clear
// sequencer. It writes CLEAR_VAL to every word and holds BUSY high for
// 2^AW cycles. Without it, BUSY is tied low and the array starts undefined.
//
// Parameters:
//   DW        data width in bits (multiple of 8)
//   AW        address width, depth = 2^AW words
//   RDW_MODE  cross-port read-during-write: 0 = old data, 1 = new merged data
//   CLEAR_VAL word written by the clear sequencer
// Ports:
//   CLK, RST_n          clock, asynchronous active-low reset
//   AA/AI/ABE/ACS/AWE   port A address, write data, byte enables, select, write
//   AO, AACK            port A registered read data, access acknowledge
//   BA/BI/BBE/BCS/BWE   port B, same meaning as port A
//   BO, BACK            port B registered read data, access acknowledge
//   BUSY                clear sequencer active, all accesses ignored
//   COLL                same-address hit on both ports with at least one write
// -----------------------------------------------------------------------------
module nx1_dpram_sc #(
  parameter int          DW        = 16,
  parameter int          AW        = 10,
  parameter int          RDW_MODE  = 0,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic [AW-1:0]   AA,
  input  logic [DW-1:0]   AI,
  input  logic [DW/8-1:0] ABE,
  input  logic            ACS,
  input  logic            AWE,
  output logic [DW-1:0]   AO,
  output logic            AACK,
  input  logic [AW-1:0]   BA,
  input  logic [DW-1:0]   BI,
  input  logic [DW/8-1:0] BBE,
  input  logic            BCS,
  input  logic            BWE,
  output logic [DW-1:0]   BO,
  output logic            BACK,
  output logic            BUSY,
  output logic            COLL
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  // Clear sequencer view seen by the datapath.
  logic          clr_active;
  logic [AW-1:0] clr_addr;

`ifdef NX1_DPRAM_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} clr_state_t;

  clr_state_t    state_reg, state_next;
  logic [AW-1:0] clr_cnt_reg, clr_cnt_next;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // One location per cycle. Leave CLEAR on the edge that writes the last word.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == {AW{1'b1}}) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_comb begin
    clr_active = (state_reg == ST_CLEAR);
    clr_addr   = clr_cnt_reg;
  end
`else
  assign clr_active = 1'b0;
  assign clr_addr   = '0;
`endif

  assign BUSY = clr_active;

  // Access qualification. The clear sequencer borrows port A's write path.
  logic acc_a, acc_b, wr_a, wr_b, rd_a, rd_b, same_addr;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_data;

  assign acc_a     = ACS & ~clr_active;
  assign acc_b     = BCS & ~clr_active;
  assign wr_a      = acc_a & AWE;
  assign wr_b      = acc_b & BWE;
  assign rd_a      = acc_a & ~AWE;
  assign rd_b      = acc_b & ~BWE;
  assign same_addr = (AA == BA);
  assign wa_addr   = clr_active ? clr_addr  : AA;
  assign wa_data   = clr_active ? CLEAR_VAL : AI;

  logic [DW-1:0] rd_a_word, rd_b_word;

  // One narrow RAM per byte lane. Each lane has its own write enables, so
  // the byte-level collision priority is resolved here. A port B write to a
  // lane is dropped only when port A writes the same lane of the same word,
  // so the two ports never write one location in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_a_reg, q_b_reg;
      logic       we_a, we_b, byp_a, byp_b;

      assign we_a = clr_active | (wr_a & ABE[gi]);
      assign we_b = wr_b & BBE[gi] & ~(same_addr & wr_a & ABE[gi]);

      // New-data mode forwards the byte being written by the other port.
      // Old-data mode relies on the array read returning the pre-edge contents.
      assign byp_a = (RDW_MODE != 0) & same_addr & we_b;
      assign byp_b = (RDW_MODE != 0) & same_addr & we_a;

      always_ff @(posedge CLK) begin
        if (we_a) mem[wa_addr] <= wa_data[gi*8 +: 8];
        if (we_b) mem[BA]      <= BI[gi*8 +: 8];
        if (rd_a) q_a_reg      <= byp_a ? BI[gi*8 +: 8] : mem[AA];
        if (rd_b) q_b_reg      <= byp_b ? AI[gi*8 +: 8] : mem[BA];
      end

      assign rd_a_word[gi*8 +: 8] = q_a_reg;
      assign rd_b_word[gi*8 +: 8] = q_b_reg;
    end
  endgenerate

  // Control and output registers. The RAM read registers cannot be reset, so
  // a valid flag forces AO/BO to zero until the first read after reset. A
  // write leaves the read register untouched, which holds the previous value.
  logic aack_reg, back_reg, coll_reg, ao_valid_reg, bo_valid_reg;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      aack_reg     <= 1'b0;
      back_reg     <= 1'b0;
      coll_reg     <= 1'b0;
      ao_valid_reg <= 1'b0;
      bo_valid_reg <= 1'b0;
    end else begin
      aack_reg     <= acc_a;
      back_reg     <= acc_b;
      coll_reg     <= acc_a & acc_b & same_addr & (AWE | BWE);
      ao_valid_reg <= ao_valid_reg | rd_a;
      bo_valid_reg <= bo_valid_reg | rd_b;
    end
  end

  assign AO   = ao_valid_reg ? rd_a_word : '0;
  assign BO   = bo_valid_reg ? rd_b_word : '0;
  assign AACK = aack_reg;
  assign BACK = back_reg;
  assign COLL = coll_reg;

endmodule

// File: tb/tb_nx1_dpram_sc.sv
// Testbench for nx1_dpram_sc: two instances (old-data and new-data
// read-during-write) share all inputs and are checked against an array model.
module tb_nx1_dpram_sc;

  localparam int          DW    = 16;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [15:0] CLR   = 16'hA5A5;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic [AW-1:0] AA = '0, BA = '0;
  logic [DW-1:0] AI = '0, BI = '0;
  logic [1:0]    ABE = '0, BBE = '0;
  logic          ACS = 1'b0, AWE = 1'b0, BCS = 1'b0, BWE = 1'b0;

  logic [DW-1:0] AO0, BO0, AO1, BO1;
  logic          AACK0, BACK0, BUSY0, COLL0, AACK1, BACK1, BUSY1, COLL1;

  always #5 CLK = ~CLK;

  nx1_dpram_sc #(.DW(DW), .AW(AW), .RDW_MODE(0), .CLEAR_VAL(CLR)) u_dut0 (
    .CLK(CLK), .RST_n(RST_n),
    .AA(AA), .AI(AI), .ABE(ABE), .ACS(ACS), .AWE(AWE), .AO(AO0), .AACK(AACK0),
    .BA(BA), .BI(BI), .BBE(BBE), .BCS(BCS), .BWE(BWE), .BO(BO0), .BACK(BACK0),
    .BUSY(BUSY0), .COLL(COLL0)
  );

  nx1_dpram_sc #(.DW(DW), .AW(AW), .RDW_MODE(1), .CLEAR_VAL(CLR)) u_dut1 (
    .CLK(CLK), .RST_n(RST_n),
    .AA(AA), .AI(AI), .ABE(ABE), .ACS(ACS), .AWE(AWE), .AO(AO1), .AACK(AACK1),
    .BA(BA), .BI(BI), .BBE(BBE), .BCS(BCS), .BWE(BWE), .BO(BO1), .BACK(BACK1),
    .BUSY(BUSY1), .COLL(COLL1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: word array with a per-byte "has been written" mask.
  logic [15:0] mem_m [DEPTH];
  logic [1:0]  kn_m  [DEPTH];
  logic [15:0] exp_ao [2];
  logic [15:0] exp_bo [2];
  bit          ao_kn [2];
  bit          bo_kn [2];
  bit          exp_aack, exp_back, exp_coll, busy_m;
  int          clr_cnt;

`ifdef NX1_DPRAM_CLEAR_EN
  localparam bit CLEAR_BUILT = 1'b1;
`else
  localparam bit CLEAR_BUILT = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      exp_ao[m] = '0; exp_bo[m] = '0; ao_kn[m] = 1'b1; bo_kn[m] = 1'b1;
    end
    exp_aack = 1'b0; exp_back = 1'b0; exp_coll = 1'b0;
    busy_m = CLEAR_BUILT;
    clr_cnt = 0;
    // The sequencer rewrites every word before any access can be accepted.
    if (CLEAR_BUILT) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_m[i] = CLR; kn_m[i] = 2'b11;
      end
    end
  endtask

  task automatic apply_wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
    for (int b = 0; b < 2; b++) begin
      if (be[b]) begin
        mem_m[a][8*b +: 8] = d[8*b +: 8];
        kn_m[a][b] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " aack0"}, {31'd0, AACK0}, {31'd0, exp_aack});
    chk({tag, " aack1"}, {31'd0, AACK1}, {31'd0, exp_aack});
    chk({tag, " back0"}, {31'd0, BACK0}, {31'd0, exp_back});
    chk({tag, " back1"}, {31'd0, BACK1}, {31'd0, exp_back});
    chk({tag, " coll0"}, {31'd0, COLL0}, {31'd0, exp_coll});
    chk({tag, " coll1"}, {31'd0, COLL1}, {31'd0, exp_coll});
    chk({tag, " busy0"}, {31'd0, BUSY0}, {31'd0, busy_m});
    chk({tag, " busy1"}, {31'd0, BUSY1}, {31'd0, busy_m});
    if (ao_kn[0]) chk({tag, " ao0"}, {16'd0, AO0}, {16'd0, exp_ao[0]});
    if (ao_kn[1]) chk({tag, " ao1"}, {16'd0, AO1}, {16'd0, exp_ao[1]});
    if (bo_kn[0]) chk({tag, " bo0"}, {16'd0, BO0}, {16'd0, exp_bo[0]});
    if (bo_kn[1]) chk({tag, " bo1"}, {16'd0, BO1}, {16'd0, exp_bo[1]});
  endtask

  // Drive one cycle of both ports, update the model at the edge, check at +1.
  task automatic do_cycle(input string tag,
                          input logic acs, input logic awe, input logic [AW-1:0] aa,
                          input logic [15:0] ai, input logic [1:0] abe,
                          input logic bcs, input logic bwe, input logic [AW-1:0] ba,
                          input logic [15:0] bi, input logic [1:0] bbe);
    bit acc_a, acc_b, same, oka, okb;
    logic [15:0] old_a, old_b;
    ACS = acs; AWE = awe; AA = aa; AI = ai; ABE = abe;
    BCS = bcs; BWE = bwe; BA = ba; BI = bi; BBE = bbe;
    @(posedge CLK);
    acc_a = acs && !busy_m;
    acc_b = bcs && !busy_m;
    same  = (aa == ba);
    old_a = mem_m[aa]; oka = (kn_m[aa] == 2'b11);
    old_b = mem_m[ba]; okb = (kn_m[ba] == 2'b11);
    // B first, then A: A's bytes overwrite B's where both are enabled.
    if (acc_b && bwe) apply_wr(ba, bi, bbe);
    if (acc_a && awe) apply_wr(aa, ai, abe);
    if (acc_a && !awe) begin
      exp_ao[0] = old_a; ao_kn[0] = oka;
      if (acc_b && bwe && same) begin
        exp_ao[1] = mem_m[aa]; ao_kn[1] = (kn_m[aa] == 2'b11);
      end else begin
        exp_ao[1] = old_a; ao_kn[1] = oka;
      end
    end
    if (acc_b && !bwe) begin
      exp_bo[0] = old_b; bo_kn[0] = okb;
      if (acc_a && awe && same) begin
        exp_bo[1] = mem_m[ba]; bo_kn[1] = (kn_m[ba] == 2'b11);
      end else begin
        exp_bo[1] = old_b; bo_kn[1] = okb;
      end
    end
    exp_aack = acc_a;
    exp_back = acc_b;
    exp_coll = acc_a && acc_b && same && (awe || bwe);
    if (busy_m) begin
      clr_cnt++;
      if (clr_cnt == DEPTH) busy_m = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    do_cycle(tag, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0, '0, '0, 2'b00);
  endtask

  // Hold reset across an edge, check async outputs, release and rerun clear.
  task automatic reset_pulse(input string tag);
    ACS = 1'b0; BCS = 1'b0; AWE = 1'b0; BWE = 1'b0;
    #1 RST_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    chk({tag, " ao0 zero"}, {16'd0, AO0}, 32'd0);
    @(posedge CLK);
    #1 RST_n = 1'b1;
  endtask

  task automatic run_clear(input string tag);
    while (busy_m) begin
      do_cycle(tag, 1'b1, 1'b0, 10'h3FF, '0, 2'b11, 1'b1, 1'b0, 10'h001, '0, 2'b11);
    end
  endtask

  initial begin
    logic [AW-1:0] ra, rb;
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0; kn_m[i] = 2'b00;
    end
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_outputs("reset");
    RST_n = 1'b1;

    // Clear sequence with both ports requesting reads: nothing is accepted.
    run_clear("clear");
    if (CLEAR_BUILT) begin
      for (int i = 0; i < 16; i++) begin
        do_cycle("clrval", 1'b1, 1'b0, AW'(i), '0, 2'b00, 1'b1, 1'b0, AW'(15 - i), '0, 2'b00);
      end
    end

    // A write to the top address, then B reads it back.
    do_cycle("wr3ff", 1'b1, 1'b1, 10'h3FF, 16'h1234, 2'b11, 1'b0, 1'b0, '0, '0, 2'b00);
    do_cycle("rd3ff", 1'b0, 1'b0, '0, '0, 2'b00, 1'b1, 1'b0, 10'h3FF, '0, 2'b00);
    chk("tp bo 3ff", {16'd0, BO0}, 32'h1234);
    idle("rd3ff idle");

    // Partial byte write.
    do_cycle("be full", 1'b1, 1'b1, 10'h020, 16'hFFFF, 2'b11, 1'b0, 1'b0, '0, '0, 2'b00);
    do_cycle("be low", 1'b1, 1'b1, 10'h020, 16'h0000, 2'b01, 1'b0, 1'b0, '0, '0, 2'b00);
    do_cycle("be rd", 1'b1, 1'b0, 10'h020, '0, 2'b00, 1'b0, 1'b0, '0, '0, 2'b00);
    chk("tp be ao", {16'd0, AO0}, 32'hFF00);

    // Both ports write one word: A wins the shared byte.
    do_cycle("ww", 1'b1, 1'b1, 10'h010, 16'h1111, 2'b01, 1'b1, 1'b1, 10'h010, 16'h2222, 2'b11);
    chk("tp ww coll", {31'd0, COLL0}, 32'd1);
    do_cycle("ww rd", 1'b1, 1'b0, 10'h010, '0, 2'b00, 1'b0, 1'b0, '0, '0, 2'b00);
    chk("tp ww word", {16'd0, AO0}, 32'h2211);
    chk("tp ww coll off", {31'd0, COLL0}, 32'd0);

    // Read during write from the other port.
    do_cycle("rdw init", 1'b1, 1'b1, 10'h030, 16'h00AA, 2'b11, 1'b0, 1'b0, '0, '0, 2'b00);
    do_cycle("rdw", 1'b1, 1'b1, 10'h030, 16'h5555, 2'b11, 1'b1, 1'b0, 10'h030, '0, 2'b00);
    chk("tp rdw old", {16'd0, BO0}, 32'h00AA);
    chk("tp rdw new", {16'd0, BO1}, 32'h5555);
    chk("tp rdw coll", {31'd0, COLL0}, 32'd1);
    do_cycle("rr", 1'b1, 1'b0, 10'h030, '0, 2'b00, 1'b1, 1'b0, 10'h030, '0, 2'b00);
    chk("tp rr coll", {31'd0, COLL1}, 32'd0);

    // Random traffic over a small address window to provoke collisions.
    for (int i = 0; i < 8; i++) begin
      do_cycle("rnd init", 1'b1, 1'b1, AW'(i), 16'($urandom), 2'b11, 1'b0, 1'b0, '0, '0, 2'b00);
    end
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rb = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      do_cycle("rnd", ($urandom_range(0, 3) != 0), 1'($urandom), ra, 16'($urandom), 2'($urandom),
               ($urandom_range(0, 3) != 0), 1'($urandom), rb, 16'($urandom), 2'($urandom));
    end

    // Reset in the middle of an acknowledged access.
    do_cycle("pre rst", 1'b1, 1'b0, 10'h3FF, '0, 2'b00, 1'b1, 1'b0, 10'h020, '0, 2'b00);
    reset_pulse("rst access");
    if (CLEAR_BUILT) begin
      // Reset again after seven clear cycles; the clear must start over.
      for (int i = 0; i < 7; i++) begin
        do_cycle("clear2", 1'b1, 1'b0, 10'h3FF, '0, 2'b00, 1'b0, 1'b0, '0, '0, 2'b00);
      end
      reset_pulse("rst clear");
    end
    run_clear("clear3");
    do_cycle("post rst", 1'b1, 1'b1, 10'h3FF, 16'hBEEF, 2'b10, 1'b1, 1'b0, 10'h3FF, '0, 2'b00);
    do_cycle("post rd", 1'b1, 1'b0, 10'h3FF, '0, 2'b00, 1'b0, 1'b0, '0, '0, 2'b00);
    idle("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
